// File: rtl/br31_pkg.sv
// Shared types and constants for the Baskin-Robbins 31 game blocks.
// Used by both the game core and the player agent.
package br31_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_OFFER,
    ST_WAIT_COMP,
    ST_DONE
  } br31_state_e;

  localparam int BR31_LIMIT      = 31;
  localparam int BR31_MAX_STEP   = 3;
  localparam int BR31_TOTAL_W    = 6;
  localparam int BR31_TARGET_MOD = 4;

  // Map two random bits onto a legal count; 0 folds onto 1.
  function automatic logic [1:0] br31_rand_move(input logic [1:0] b);
    return (b == 2'd0) ? 2'd1 : b;
  endfunction

endpackage

// File: rtl/br31_lfsr.sv
// Free-running 8-bit maximal-length LFSR, x^8+x^6+x^5+x^4+1.
// A zero seed would lock up, so it is replaced by 8'h01.
module br31_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] o_lfsr
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign o_lfsr = r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED_EFF;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

endmodule

// File: rtl/br31_player_agent.sv
// Player-side agent for the BR31 core: offers counts over valid/ready,
// absorbs computer replies, tracks the total and declares the result.
module br31_player_agent
  import br31_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter bit         STRATEGIC = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    move_valid,
  input  logic                    move_ready,
  output logic [1:0]              player_in,
  input  logic                    comp_valid,
  input  logic [1:0]              comp_in,
  output logic [BR31_TOTAL_W-1:0] total,
  output logic                    game_over,
  output logic                    player_win,
  output logic                    illegal_move
);

  localparam logic [BR31_TOTAL_W-1:0] LIMIT = BR31_TOTAL_W'(BR31_LIMIT);

  br31_state_e r_state, w_state_nx;

  logic [BR31_TOTAL_W-1:0] r_total, w_total_nx;
  logic [1:0]              r_pin, w_pin_nx;
  logic                    r_mv, w_mv_nx;
  logic                    r_go, w_go_nx;
  logic                    r_win, w_win_nx;
  logic                    r_ill, w_ill_nx;

  logic [7:0]              w_lfsr;
  logic                    w_unused;
  logic [1:0]              w_strat;
  logic [1:0]              w_rnd;
  logic [1:0]              w_raw;
  logic [1:0]              w_move;
  logic [BR31_TOTAL_W-1:0] w_rem;
  logic [BR31_TOTAL_W-1:0] w_sum_p;
  logic [BR31_TOTAL_W-1:0] w_sum_c;

  br31_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .o_lfsr(w_lfsr)
  );

  assign w_unused = ^w_lfsr[7:2];

  // Strategic target is total == 2 (mod 4); the 2-bit wrap does the mod.
  assign w_strat = 2'd2 - r_total[1:0];
  assign w_rnd   = br31_rand_move(w_lfsr[1:0]);
  assign w_raw   = (!STRATEGIC || w_strat == 2'd0) ? w_rnd : w_strat;
  assign w_rem   = LIMIT - r_total;

  always_comb begin
    w_move = w_raw;
    if (w_rem < {{(BR31_TOTAL_W-2){1'b0}}, w_raw}) begin
      w_move = w_rem[1:0];
    end
    if (w_move == 2'd0) begin
      w_move = 2'd1;
    end
  end

  assign w_sum_p = r_total + {{(BR31_TOTAL_W-2){1'b0}}, r_pin};
  assign w_sum_c = r_total + {{(BR31_TOTAL_W-2){1'b0}}, comp_in};

  always_comb begin
    w_state_nx = r_state;
    w_total_nx = r_total;
    w_pin_nx   = r_pin;
    w_mv_nx    = r_mv;
    w_go_nx    = r_go;
    w_win_nx   = r_win;
    w_ill_nx   = r_ill;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_total_nx = '0;
          w_go_nx    = 1'b0;
          w_win_nx   = 1'b0;
          w_ill_nx   = 1'b0;
          w_state_nx = ST_CALC;
        end
      end
      ST_CALC: begin
        w_pin_nx   = w_move;
        w_mv_nx    = 1'b1;
        w_state_nx = ST_OFFER;
      end
      ST_OFFER: begin
        if (r_mv && move_ready) begin
          w_mv_nx    = 1'b0;
          w_total_nx = w_sum_p;
          if (w_sum_p >= LIMIT) begin
            w_go_nx    = 1'b1;
            w_win_nx   = 1'b0;
            w_state_nx = ST_DONE;
          end else begin
            w_state_nx = ST_WAIT_COMP;
          end
        end
      end
      ST_WAIT_COMP: begin
        if (comp_valid) begin
          if (comp_in == 2'd0) begin
            w_ill_nx   = 1'b1;
            w_go_nx    = 1'b1;
            w_win_nx   = 1'b1;
            w_state_nx = ST_DONE;
          end else begin
            w_total_nx = w_sum_c;
            if (w_sum_c >= LIMIT) begin
              w_go_nx    = 1'b1;
              w_win_nx   = 1'b1;
              w_state_nx = ST_DONE;
            end else begin
              w_state_nx = ST_CALC;
            end
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_total <= '0;
      r_pin   <= 2'd0;
      r_mv    <= 1'b0;
      r_go    <= 1'b0;
      r_win   <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_total <= w_total_nx;
      r_pin   <= w_pin_nx;
      r_mv    <= w_mv_nx;
      r_go    <= w_go_nx;
      r_win   <= w_win_nx;
      r_ill   <= w_ill_nx;
    end
  end

  assign move_valid   = r_mv;
  assign player_in    = r_pin;
  assign total        = r_total;
  assign game_over    = r_go;
  assign player_win   = r_win;
  assign illegal_move = r_ill;

endmodule

// File: tb/tb_br31_player_agent.sv
// Scoreboard bench for br31_player_agent: a strategic and a random
// instance share stimulus; sel picks which one is being scored.
module tb_br31_player_agent;

  logic       clk;
  logic       reset;
  logic       start;
  logic       move_ready;
  logic       comp_valid;
  logic [1:0] comp_in;
  logic       sel;

  logic       d_mv, d_go, d_win, d_ill;
  logic [1:0] d_pin;
  logic [5:0] d_tot;
  logic       r_mv, r_go, r_win, r_ill;
  logic [1:0] r_pin;
  logic [5:0] r_tot;

  logic       m_mv, m_go, m_win, m_ill;
  logic [1:0] m_pin;
  logic [5:0] m_tot;

  localparam logic [7:0] RND_SEED = 8'h5C;

  br31_player_agent #(.LFSR_SEED(8'hA5), .STRATEGIC(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .move_valid(d_mv), .move_ready(move_ready), .player_in(d_pin),
    .comp_valid(comp_valid), .comp_in(comp_in), .total(d_tot),
    .game_over(d_go), .player_win(d_win), .illegal_move(d_ill)
  );

  br31_player_agent #(.LFSR_SEED(RND_SEED), .STRATEGIC(1'b0)) u_rnd (
    .clk(clk), .reset(reset), .start(start),
    .move_valid(r_mv), .move_ready(move_ready), .player_in(r_pin),
    .comp_valid(comp_valid), .comp_in(comp_in), .total(r_tot),
    .game_over(r_go), .player_win(r_win), .illegal_move(r_ill)
  );

  assign m_mv  = sel ? r_mv  : d_mv;
  assign m_pin = sel ? r_pin : d_pin;
  assign m_tot = sel ? r_tot : d_tot;
  assign m_go  = sel ? r_go  : d_go;
  assign m_win = sel ? r_win : d_win;
  assign m_ill = sel ? r_ill : d_ill;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int tot;
    int go;
    int win;
    int ill;
  } exp_t;

  exp_t q_st[$];
  int   q_pi[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   pend = 1'b0;

  int   exp_tot, exp_go, exp_win, exp_ill, last_pi;
  logic [7:0] mlfsr;

  // Reference LFSR for the random instance, from the polynomial.
  always @(posedge clk) begin
    if (reset) mlfsr <= RND_SEED;
    else mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st();
    exp_t e;
    e.tot = exp_tot; e.go = exp_go; e.win = exp_win; e.ill = exp_ill;
    q_st.push_back(e);
  endtask

  task automatic clear_model();
    exp_tot = 0; exp_go = 0; exp_win = 0; exp_ill = 0;
  endtask

  task automatic predict_move();
    int m;
    m = ((2 - exp_tot) % 4 + 4) % 4;
    if (sel || m == 0) m = (mlfsr[1:0] == 2'd0) ? 1 : int'(mlfsr[1:0]);
    if (m > 31 - exp_tot) m = 31 - exp_tot;
    if (m < 1) m = 1;
    last_pi = m;
    q_pi.push_back(m);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_model();
    check("calc_mv_low", m_mv, 0);
    predict_move();
  endtask

  task automatic player_turn(input int stall);
    int w;
    w = 0;
    while (!m_mv && w < 8) begin
      tick();
      w++;
    end
    check("mv_latency", w, 1);
    if (!m_mv) return;
    check("pin_range", int'(m_pin >= 2'd1), 1);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("bp_valid", m_mv, 1);
      check("bp_pin", m_pin, last_pi);
      check("bp_total", m_tot, exp_tot);
    end
    move_ready = 1'b1;
    exp_tot += last_pi;
    if (exp_tot >= 31) begin
      exp_go = 1; exp_win = 0;
    end
    push_st();
    tick();
    move_ready = 1'b0;
  endtask

  task automatic comp_turn(input logic [1:0] c);
    comp_valid = 1'b1;
    comp_in = c;
    if (c == 2'd0) begin
      exp_ill = 1; exp_go = 1; exp_win = 1;
    end else begin
      exp_tot += int'(c);
      if (exp_tot >= 31) begin
        exp_go = 1; exp_win = 1;
      end
    end
    push_st();
    tick();
    comp_valid = 1'b0;
    comp_in = 2'd0;
    if (!exp_go) predict_move();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mv"}, m_mv, 0);
    check({tag, "_pin"}, m_pin, 0);
    check({tag, "_total"}, m_tot, 0);
    check({tag, "_go"}, m_go, 0);
    check({tag, "_win"}, m_win, 0);
    check({tag, "_ill"}, m_ill, 0);
  endtask

  // Monitor: a handshake or comp pulse seen here is scored next cycle.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      if (q_st.size() == 0) begin
        check("sb_state_empty", 0, 1);
      end else begin
        e = q_st.pop_front();
        check("sb_total", m_tot, e.tot);
        check("sb_over", m_go, e.go);
        check("sb_win", m_win, e.win);
        check("sb_illegal", m_ill, e.ill);
        check("sb_mv_low", m_mv, 0);
      end
      pend = 1'b0;
    end
    if (m_mv && move_ready) begin
      if (q_pi.size() == 0) check("sb_move_empty", 0, 1);
      else check("sb_player_in", m_pin, q_pi.pop_front());
      pend = 1'b1;
    end
    if (comp_valid) pend = 1'b1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int moves, games, losses, w;
    logic [1:0] c;
    reset = 1'b1; start = 1'b0; move_ready = 1'b0;
    comp_valid = 1'b0; comp_in = 2'd0; sel = 1'b0;
    clear_model();
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Opening: 0 -> 2, +3 -> 5 -> 6, then an illegal reply.
    do_start();
    player_turn(0);
    comp_turn(2'd3);
    player_turn(0);
    comp_turn(2'd0);
    tick();

    // Full game against a computer that always plays 1, with stall.
    do_start();
    player_turn(5);
    for (int k = 0; k < 20 && !exp_go; k++) begin
      comp_turn(2'd1);
      if (exp_go) break;
      player_turn(0);
    end
    check("full_total", exp_tot, 31);
    tick();

    // Reset while an offer is pending.
    do_start();
    w = 0;
    while (!m_mv && w < 8) begin
      tick();
      w++;
    end
    check("offer_up", m_mv, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q_pi.delete();
    clear_model();
    check_zero("midrst");
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    tick();
    check("rst_beats_start", m_mv, 0);
    for (int k = 0; k < 3; k++) begin
      comp_valid = 1'b1; comp_in = 2'd2;
      push_st();
      tick();
      comp_valid = 1'b0; comp_in = 2'd0;
      tick();
    end

    // Random instance: 200 moves, computer steers toward 30 when it can.
    sel = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    tick();
    moves = 0; games = 0; losses = 0;
    while (moves < 200 && games < 80) begin
      do_start();
      for (int k = 0; k < 20; k++) begin
        player_turn(0);
        moves++;
        if (exp_go) break;
        if (exp_tot >= 27 && exp_tot <= 29) c = 2'(30 - exp_tot);
        else c = 2'((exp_tot % 3) + 1);
        comp_turn(c);
        if (exp_go) break;
      end
      if (exp_go && !exp_win) losses++;
      games++;
      tick();
    end
    check("rnd_moves", int'(moves >= 200), 1);
    check("forced_loss_seen", int'(losses > 0), 1);

    repeat (3) tick();
    check("sb_state_drained", q_st.size(), 0);
    check("sb_move_drained", q_pi.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
